// File: rtl/systolic_array_param.sv
`default_nettype none
// ============================================================================
// Module      : systolic_array_param
// Description : N x N output-stationary systolic matrix engine. Streams
//               column k of A and row k of W for K beats, skews them into
//               the PE grid, lets the wavefront drain, then presents each
//               row of C = A x W requantised (arithmetic shift + saturate)
//               and optionally ReLU-activated over a valid/ready port.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               start, k_len, shift,
//               act_mode             - job launch and job configuration
//               pause                - freeze all state (outside IDLE)
//               in_valid/in_ready,
//               a_in, w_in           - operand beat stream
//               out_valid/out_ready,
//               out_row, out_data    - result row stream
//               busy, done           - job status
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_array_param #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int AW = 24,
    parameter int KW = 8,
    localparam int RW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    input  logic [4:0]      shift,
    input  logic            act_mode,
    input  logic            pause,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] a_in,
    input  logic [N*DW-1:0] w_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [RW-1:0]   out_row,
    output logic [N*DW-1:0] out_data,
    output logic            busy,
    output logic            done
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_LOAD   = 2'd1;
    localparam logic [1:0] c_FLUSH  = 2'd2;
    localparam logic [1:0] c_OUTPUT = 2'd3;

    localparam int FCW = $clog2(3 * N);
    // Last flush cycle index; the drain needs 2N-2 cycles, 3N-2 leaves margin.
    localparam logic [FCW-1:0] c_FLUSH_LAST = FCW'(3 * N - 3);

    localparam logic signed [AW-1:0] c_QMAX = AW'((1 << (DW - 1)) - 1);
    localparam logic signed [AW-1:0] c_QMIN = ~c_QMAX;

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [KW-1:0]   r_k;
    logic [4:0]      r_shift;
    logic            r_act;
    logic [KW-1:0]   r_beat;
    logic [FCW-1:0]  r_flush;
    logic [RW-1:0]   r_out_row;
    logic            r_out_valid;
    logic [N*DW-1:0] r_out_data;
    logic            r_done;

    logic            w_adv;
    logic            w_beat;
    logic            w_clear;
    logic            w_xfer;
    logic [RW-1:0]   w_sel_row;
    logic [N*DW-1:0] w_q_row;

    // Datapath state only moves when not paused; IDLE holds nothing but zeros.
    assign w_adv   = !pause;
    assign w_beat  = (r_state == c_LOAD) && !pause && in_valid;
    assign w_clear = (r_state == c_IDLE) && start;
    assign w_xfer  = r_out_valid && out_ready && !pause;

    // Row to requantise next: row 0 on entry to OUTPUT, else the following row.
    assign w_sel_row = (r_state == c_OUTPUT) ? (r_out_row + RW'(1)) : '0;

    assign in_ready  = (r_state == c_LOAD) && !pause;
    assign busy      = (r_state != c_IDLE);
    assign done      = r_done;
    assign out_valid = r_out_valid;
    assign out_row   = r_out_row;
    assign out_data  = r_out_data;

    // ------------------------------------------------------------------------
    // Operand buses. Column 0 of the A bus / row 0 of the W bus is fed by the
    // skew lines; later entries are the forwarding registers of the PE before.
    // ------------------------------------------------------------------------
    logic signed [DW-1:0] w_a_bus [N][N];
    logic                 w_a_vld [N][N];
    logic signed [DW-1:0] w_w_bus [N][N];
    logic                 w_w_vld [N][N];
    logic signed [AW-1:0] w_acc   [N][N];

    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_skew
            if (gi == 0) begin : g_direct
                assign w_a_bus[0][0] = w_beat ? a_in[0 +: DW] : '0;
                assign w_a_vld[0][0] = w_beat;
                assign w_w_bus[0][0] = w_beat ? w_in[0 +: DW] : '0;
                assign w_w_vld[0][0] = w_beat;
            end else begin : g_delay
                // gi-stage delay lines; bubbles enter as zero with valid low.
                logic signed [DW-1:0] r_ad [gi];
                logic                 r_av [gi];
                logic signed [DW-1:0] r_wd [gi];
                logic                 r_wv [gi];
                always_ff @(posedge clk) begin
                    if (rst) begin
                        for (int d = 0; d < gi; d++) begin
                            r_ad[d] <= '0;
                            r_av[d] <= 1'b0;
                            r_wd[d] <= '0;
                            r_wv[d] <= 1'b0;
                        end
                    end else if (w_adv) begin
                        r_ad[0] <= w_beat ? a_in[gi*DW +: DW] : '0;
                        r_av[0] <= w_beat;
                        r_wd[0] <= w_beat ? w_in[gi*DW +: DW] : '0;
                        r_wv[0] <= w_beat;
                        for (int d = 1; d < gi; d++) begin
                            r_ad[d] <= r_ad[d-1];
                            r_av[d] <= r_av[d-1];
                            r_wd[d] <= r_wd[d-1];
                            r_wv[d] <= r_wv[d-1];
                        end
                    end
                end
                assign w_a_bus[gi][0] = r_ad[gi-1];
                assign w_a_vld[gi][0] = r_av[gi-1];
                assign w_w_bus[0][gi] = r_wd[gi-1];
                assign w_w_vld[0][gi] = r_wv[gi-1];
            end
        end

        for (gi = 0; gi < N; gi++) begin : g_row
            for (gj = 0; gj < N; gj++) begin : g_col
                logic signed [AW-1:0]   r_acc;
                logic signed [2*DW-1:0] w_prod;

                assign w_prod = w_a_bus[gi][gj] * w_w_bus[gi][gj];

                always_ff @(posedge clk) begin
                    if (rst || w_clear) begin
                        r_acc <= '0;
                    end else if (w_adv && w_a_vld[gi][gj] && w_w_vld[gi][gj]) begin
                        r_acc <= r_acc + AW'(w_prod);
                    end
                end
                assign w_acc[gi][gj] = r_acc;

                if (gj < N - 1) begin : g_east
                    logic signed [DW-1:0] r_a;
                    logic                 r_av;
                    always_ff @(posedge clk) begin
                        if (rst) begin
                            r_a  <= '0;
                            r_av <= 1'b0;
                        end else if (w_adv) begin
                            r_a  <= w_a_bus[gi][gj];
                            r_av <= w_a_vld[gi][gj];
                        end
                    end
                    assign w_a_bus[gi][gj+1] = r_a;
                    assign w_a_vld[gi][gj+1] = r_av;
                end

                if (gi < N - 1) begin : g_south
                    logic signed [DW-1:0] r_w;
                    logic                 r_wv;
                    always_ff @(posedge clk) begin
                        if (rst) begin
                            r_w  <= '0;
                            r_wv <= 1'b0;
                        end else if (w_adv) begin
                            r_w  <= w_w_bus[gi][gj];
                            r_wv <= w_w_vld[gi][gj];
                        end
                    end
                    assign w_w_bus[gi+1][gj] = r_w;
                    assign w_w_vld[gi+1][gj] = r_wv;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Requantisation: arithmetic shift, saturate to DW bits, optional ReLU.
    // ------------------------------------------------------------------------
    function automatic logic [DW-1:0] f_quant(
        input logic signed [AW-1:0] acc,
        input logic [4:0]           sh,
        input logic                 relu
    );
        logic signed [AW-1:0] s;
        logic [DW-1:0]        r;
        s = acc >>> sh;
        if (s > c_QMAX) begin
            r = c_QMAX[DW-1:0];
        end else if (s < c_QMIN) begin
            r = c_QMIN[DW-1:0];
        end else begin
            r = s[DW-1:0];
        end
        if (relu && r[DW-1]) begin
            r = '0;
        end
        return r;
    endfunction

    generate
        for (gj = 0; gj < N; gj++) begin : g_quant
            assign w_q_row[gj*DW +: DW] = f_quant(w_acc[w_sel_row][gj], r_shift, r_act);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_k         <= '0;
            r_shift     <= '0;
            r_act       <= 1'b0;
            r_beat      <= '0;
            r_flush     <= '0;
            r_out_row   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_k     <= k_len;
                        r_shift <= shift;
                        r_act   <= act_mode;
                        r_beat  <= '0;
                        r_flush <= '0;
                        if (k_len == '0) begin
                            // Accumulators are being cleared on this same edge,
                            // so the first row is known to be all zero.
                            r_state     <= c_OUTPUT;
                            r_out_row   <= '0;
                            r_out_valid <= 1'b1;
                            r_out_data  <= '0;
                        end else begin
                            r_state <= c_LOAD;
                        end
                    end
                end
                c_LOAD: begin
                    if (w_beat) begin
                        r_beat <= r_beat + KW'(1);
                        if ((r_beat + KW'(1)) == r_k) begin
                            r_state <= c_FLUSH;
                            r_flush <= '0;
                        end
                    end
                end
                c_FLUSH: begin
                    if (!pause) begin
                        if (r_flush == c_FLUSH_LAST) begin
                            r_state     <= c_OUTPUT;
                            r_out_row   <= '0;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_q_row;
                        end else begin
                            r_flush <= r_flush + FCW'(1);
                        end
                    end
                end
                c_OUTPUT: begin
                    if (w_xfer) begin
                        if (r_out_row == RW'(N - 1)) begin
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= c_IDLE;
                        end else begin
                            r_out_row  <= w_sel_row;
                            r_out_data <= w_q_row;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
